// File: rtl/mem_initiator_pkg.sv
// Shared widths and defaults for the memory-bus initiator and its timeout counter.
package mem_initiator_pkg;

  localparam int WORD_W              = 36;
  localparam int PADDR_W             = 22;
  localparam int MEM_TIMEOUT_DEFAULT = 64;

  // Counter width for a given timeout; never narrower than one bit.
  function automatic int ctr_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-cycle counter: clear on accept, count while enabled, flag at TIMEOUT-1.
// One-cycle registered count; no backpressure, expired is combinational from the count.
module mem_timeout_ctr
  import mem_initiator_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Holding at LAST keeps the count from wrapping back into a live window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Memory-bus master: one read/write at a time, strobes held until ack or timeout.
// Read completes 2 edges after accept (IACK=0) or via RD_DATA (IACK=1); resp_valid has no backpressure.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int IACK    = 0,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [PADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_rdata,
  output logic               resp_error,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [WORD_W-1:0]  mem_read_data,
  input  logic               read_ack,
  input  logic               write_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  localparam bit IMM_ACK = (IACK != 0);

  state_e               state_q, state_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_error_q, resp_error_d;
  logic [WORD_W-1:0]    resp_rdata_q, resp_rdata_d;
  logic [PADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic rd_wait;
  logic wr_wait;
  logic rd_ack;
  logic wr_ack;
  logic ack_seen;
  logic accept;
  logic tmo_expired;

  assign rd_wait  = (state_q == RD_WAIT);
  assign wr_wait  = (state_q == WR_WAIT);
  assign rd_ack   = rd_wait & read_ack;
  assign wr_ack   = wr_wait & write_ack;
  assign ack_seen = rd_ack | wr_ack;
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // With a combinational ack the strobe must not depend on it, or the two would form a loop.
  assign mem_read  = IMM_ACK ? rd_wait : (rd_wait & ~read_ack);
  assign mem_write = IMM_ACK ? wr_wait : (wr_wait & ~write_ack);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable ((rd_wait | wr_wait) & ~ack_seen),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          state_d     = req_write ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (read_ack) begin
          if (IMM_ACK) begin
            state_d = RD_DATA;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = mem_read_data;
            state_d      = IDLE;
          end
        end else if (tmo_expired) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_WAIT: begin
        if (write_ack) begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (tmo_expired) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_DATA: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_read_data;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule
